// File: rtl/uart_line_rx.sv
// rtl/uart_line_rx.sv - assembles uart_rx bytes into LF-terminated lines and replays them as a stream
//
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   rx_data/_valid/_ready         byte input from uart_rx (valid/ready)
//   line_data/_valid/_ready/_last line output stream, one line per burst
//   line_len                      byte count of the line being drained (held until next commit)
//   line_done                     1-cycle pulse when a line is committed
//   err_overflow, err_timeout     1-cycle error pulses
//   line_count                    lines fully drained, wrapping
module uart_line_rx #(
    parameter int MAX_LEN     = 32,
    parameter int TIMEOUT_CYC = 2700000,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             rx_data_ready,
    output logic [7:0]       line_data,
    output logic             line_valid,
    input  logic             line_ready,
    output logic             line_last,
    output logic [LEN_W-1:0] line_len,
    output logic             line_done,
    output logic             err_overflow,
    output logic             err_timeout,
    output logic [15:0]      line_count
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      idle_q, idle_d;
    logic [15:0]      count_q, count_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             wr_en;
    logic             rx_acc;
    logic             out_acc;
    logic [7:0]       line_buf_q [MAX_LEN];

    // Outputs decode the registered state so an asynchronous reset drops line_valid at once.
    assign line_valid    = (state_q == DRAIN);
    assign rx_data_ready = (state_q != DRAIN);
    assign line_last     = line_valid && (rd_ptr_q == len_q - LEN_ONE);
    assign line_data     = line_valid ? line_buf_q[rd_ptr_q[IDX_W-1:0]] : 8'h00;
    assign line_len      = len_q;
    assign line_done     = done_q;
    assign err_overflow  = ovf_q;
    assign err_timeout   = tmo_q;
    assign line_count    = count_q;

    assign rx_acc  = rx_data_valid && rx_data_ready;
    assign out_acc = line_valid && line_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        idle_d   = 32'd0;
        count_d  = count_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        tmo_d    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (wr_ptr_q != '0) begin
                    idle_d = idle_q + 32'd1;
                end
                if (rx_acc) begin
                    // An accepted byte always restarts the idle window, even on the expiry cycle.
                    idle_d = 32'd0;
                    if (rx_data == CHAR_CR) begin
                        state_d = COLLECT;
                    end else if (rx_data == CHAR_LF) begin
                        if (wr_ptr_q != '0) begin
                            len_d    = wr_ptr_q;
                            rd_ptr_d = '0;
                            done_d   = 1'b1;
                            state_d  = DRAIN;
                        end
                    end else if (wr_ptr_q == LEN_MAX) begin
                        ovf_d    = 1'b1;
                        wr_ptr_d = '0;
                        state_d  = DISCARD;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + LEN_ONE;
                    end
                end else if ((TIMEOUT_CYC != 0) && (wr_ptr_q != '0) && (idle_q == TMO_LAST)) begin
                    wr_ptr_d = '0;
                    idle_d   = 32'd0;
                    tmo_d    = 1'b1;
                end
            end
            DISCARD: begin
                if (rx_acc && (rx_data == CHAR_LF)) begin
                    wr_ptr_d = '0;
                    state_d  = COLLECT;
                end
            end
            DRAIN: begin
                if (out_acc) begin
                    if (line_last) begin
                        wr_ptr_d = '0;
                        count_d  = count_q + 16'd1;
                        state_d  = COLLECT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + LEN_ONE;
                    end
                end
            end
            default: begin
                wr_ptr_d = '0;
                state_d  = COLLECT;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= COLLECT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            idle_q   <= 32'd0;
            count_q  <= 16'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            idle_q   <= idle_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    // Line storage carries no reset; contents are only read below the committed length.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            line_buf_q[wr_ptr_q[IDX_W-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_line_rx.sv
// tb/tb_uart_line_rx.sv - directed self-checking bench for uart_line_rx
module tb_uart_line_rx;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [7:0] line_data;
    logic       line_valid;
    logic       line_ready;
    logic       line_last;
    logic [5:0] line_len;
    logic       line_done;
    logic       err_overflow;
    logic       err_timeout;
    logic [15:0] line_count;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] out_q [$];
    logic       last_q [$];
    int cyc = 0;
    int last_beat_cyc = -1;
    int last_acc_cyc = -1;
    int done_cnt = 0;
    int ovf_cnt = 0;
    int tmo_cnt = 0;
    int lv_cnt = 0;
    int drain_rdy_viol = 0;
    int stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic [5:0] prev_len = 6'd0;

    uart_line_rx #(.MAX_LEN(32), .TIMEOUT_CYC(100)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .line_data     (line_data),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .line_last     (line_last),
        .line_len      (line_len),
        .line_done     (line_done),
        .err_overflow  (err_overflow),
        .err_timeout   (err_timeout),
        .line_count    (line_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Observe handshakes and pulses mid-cycle; inputs change at posedge+1.
    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (line_valid) lv_cnt = lv_cnt + 1;
        if (line_valid && line_ready) begin
            out_q.push_back(line_data);
            last_q.push_back(line_last);
            if (line_last) last_beat_cyc = cyc;
        end
        if (rx_data_valid && rx_data_ready) last_acc_cyc = cyc;
        if (line_done) done_cnt = done_cnt + 1;
        if (err_overflow) ovf_cnt = ovf_cnt + 1;
        if (err_timeout) tmo_cnt = tmo_cnt + 1;
        if (line_valid && rx_data_ready) drain_rdy_viol = drain_rdy_viol + 1;
        if (prev_stall && line_valid &&
            (line_data !== prev_data || line_last !== prev_last || line_len !== prev_len))
            stall_viol = stall_viol + 1;
        prev_stall = line_valid && !line_ready;
        prev_data  = line_data;
        prev_last  = line_last;
        prev_len   = line_len;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        rx_data = b;
        rx_data_valid = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            acc = rx_data_ready;
            @(posedge sys_clk);
            #1;
            n++;
        end while (!acc && n < 200);
        rx_data_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL send_byte_timeout: byte %02h not accepted, ready=%0b want 1", b, rx_data_ready);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic clear_obs();
        out_q.delete();
        last_q.delete();
    endtask

    function automatic int first_diff(input string s);
        if (out_q.size() != s.len()) return -2;
        for (int i = 0; i < s.len(); i++)
            if (out_q[i] !== s[i]) return i;
        return -1;
    endfunction

    function automatic int last_bad();
        for (int i = 0; i < last_q.size(); i++)
            if (last_q[i] !== (i == last_q.size() - 1)) return i;
        return -1;
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b0;
        rx_data = 8'h00;
        rx_data_valid = 1'b0;
        line_ready = 1'b1;
        #1;
        n_total++; if (line_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", line_valid); else n_pass++;
        n_total++; if (rx_data_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", rx_data_ready); else n_pass++;
        n_total++;
        if ({line_last, line_done, err_overflow, err_timeout} !== 4'b0000)
            $display("FAIL rst_pulses: got %04b want 0000", {line_last, line_done, err_overflow, err_timeout});
        else n_pass++;
        n_total++; if (line_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", line_count); else n_pass++;
        n_total++; if (line_len !== 6'd0) $display("FAIL rst_len: got %0d want 0", line_len); else n_pass++;
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_empty_lines();
        int d0, lv0;
        clear_obs();
        d0 = done_cnt;
        lv0 = lv_cnt;
        send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h0A); send_byte(8'h0D);
        tick(5);
        n_total++; if (lv_cnt - lv0 !== 0) $display("FAIL empty_valid: got %0d cycles want 0", lv_cnt - lv0); else n_pass++;
        n_total++; if (done_cnt - d0 !== 0) $display("FAIL empty_done: got %0d want 0", done_cnt - d0); else n_pass++;
        n_total++; if (line_count !== 16'd0) $display("FAIL empty_count: got %0d want 0", line_count); else n_pass++;
    endtask

    task automatic test_basic_line();
        int d0;
        clear_obs();
        d0 = done_cnt;
        line_ready = 1'b1;
        send_str("Hello Tang Nano 20K");
        send_byte(8'h0D);
        send_byte(8'h0A);
        tick(40);
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL basic_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_total++; if (line_len !== 6'd19) $display("FAIL basic_len: got %0d want 19", line_len); else n_pass++;
        n_total++; if (first_diff("Hello Tang Nano 20K") !== -1) $display("FAIL basic_data: diff at %0d (size %0d) want -1", first_diff("Hello Tang Nano 20K"), out_q.size()); else n_pass++;
        n_total++; if (last_bad() !== -1) $display("FAIL basic_last: bad at %0d want -1", last_bad()); else n_pass++;
        n_total++; if (line_count !== 16'd1) $display("FAIL basic_count: got %0d want 1", line_count); else n_pass++;
    endtask

    task automatic test_stall_hold();
        logic [15:0] c0;
        logic [3:0]  pat;
        int          i;
        clear_obs();
        pat = 4'b1001;
        c0 = line_count;
        stall_viol = 0;
        drain_rdy_viol = 0;
        send_str("Hello Tang Nano 20K");
        send_byte(8'h0D);
        send_byte(8'h0A);
        rx_data = 8'h5A;
        rx_data_valid = 1'b1;
        i = 0;
        while (line_count == c0 && i < 200) begin
            line_ready = pat[i % 4];
            tick(1);
            i++;
        end
        tick(1);
        rx_data_valid = 1'b0;
        line_ready = 1'b1;
        n_total++; if (line_count !== c0 + 16'd1) $display("FAIL stall_count: got %0d want %0d", line_count, c0 + 16'd1); else n_pass++;
        n_total++; if (first_diff("Hello Tang Nano 20K") !== -1) $display("FAIL stall_data: diff at %0d want -1", first_diff("Hello Tang Nano 20K")); else n_pass++;
        n_total++; if (last_bad() !== -1) $display("FAIL stall_last: bad at %0d want -1", last_bad()); else n_pass++;
        n_total++; if (stall_viol !== 0) $display("FAIL stall_hold: got %0d changes want 0", stall_viol); else n_pass++;
        n_total++; if (drain_rdy_viol !== 0) $display("FAIL stall_rx_ready: got %0d cycles want 0", drain_rdy_viol); else n_pass++;
        n_total++; if (last_acc_cyc !== last_beat_cyc + 1) $display("FAIL stall_held_accept: got cycle %0d want %0d", last_acc_cyc, last_beat_cyc + 1); else n_pass++;
        clear_obs();
        send_byte(8'h0A);
        tick(10);
        n_total++; if (first_diff("Z") !== -1) $display("FAIL stall_held_byte: diff at %0d want -1", first_diff("Z")); else n_pass++;
    endtask

    task automatic test_overflow();
        string s;
        int    o0, d0;
        clear_obs();
        s = "";
        for (int i = 0; i < 32; i++) s = {s, "A"};
        send_str(s);
        send_byte(8'h0A);
        tick(45);
        n_total++; if (line_len !== 6'd32) $display("FAIL full_len: got %0d want 32", line_len); else n_pass++;
        n_total++; if (first_diff(s) !== -1) $display("FAIL full_data: diff at %0d (size %0d) want -1", first_diff(s), out_q.size()); else n_pass++;
        n_total++; if (last_bad() !== -1) $display("FAIL full_last: bad at %0d want -1", last_bad()); else n_pass++;
        clear_obs();
        o0 = ovf_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 32; i++) send_byte("B");
        n_total++; if (err_overflow !== 1'b0) $display("FAIL ovf_early: got %0b want 0", err_overflow); else n_pass++;
        send_byte("B");
        n_total++; if (err_overflow !== 1'b1) $display("FAIL ovf_33rd: got %0b want 1", err_overflow); else n_pass++;
        for (int i = 0; i < 7; i++) send_byte("B");
        send_byte(8'h0A);
        tick(10);
        n_total++; if (ovf_cnt - o0 !== 1) $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - o0); else n_pass++;
        n_total++; if (out_q.size() !== 0 || done_cnt != d0) $display("FAIL ovf_no_output: got %0d beats %0d done want 0 0", out_q.size(), done_cnt - d0); else n_pass++;
        send_str("ok");
        send_byte(8'h0A);
        tick(10);
        n_total++; if (first_diff("ok") !== -1) $display("FAIL ovf_recover: diff at %0d (size %0d) want -1", first_diff("ok"), out_q.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        int early, t0;
        clear_obs();
        t0 = tmo_cnt;
        send_str("ab");
        early = 0;
        for (int i = 0; i < 99; i++) begin
            tick(1);
            if (err_timeout) early++;
        end
        n_total++; if (early !== 0) $display("FAIL tmo_early: got %0d pulses want 0", early); else n_pass++;
        tick(1);
        n_total++; if (err_timeout !== 1'b1) $display("FAIL tmo_at_100: got %0b want 1", err_timeout); else n_pass++;
        tick(3);
        n_total++; if (tmo_cnt - t0 !== 1) $display("FAIL tmo_pulses: got %0d want 1", tmo_cnt - t0); else n_pass++;
        send_str("cd");
        send_byte(8'h0A);
        tick(10);
        n_total++; if (line_len !== 6'd2) $display("FAIL tmo_len: got %0d want 2", line_len); else n_pass++;
        n_total++; if (first_diff("cd") !== -1) $display("FAIL tmo_data: diff at %0d (size %0d) want -1", first_diff("cd"), out_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        int n;
        clear_obs();
        line_ready = 1'b1;
        send_str("0123456789");
        send_byte(8'h0A);
        n = 0;
        while (out_q.size() < 3 && n < 50) begin
            tick(1);
            n++;
        end
        n_total++; if (line_valid !== 1'b1) $display("FAIL mid_drain_active: got %0b want 1", line_valid); else n_pass++;
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_total++; if (line_valid !== 1'b0) $display("FAIL async_valid: got %0b want 0", line_valid); else n_pass++;
        n_total++; if (line_count !== 16'd0) $display("FAIL async_count: got %0d want 0", line_count); else n_pass++;
        n_total++; if (rx_data_ready !== 1'b1) $display("FAIL async_ready: got %0b want 1", rx_data_ready); else n_pass++;
        tick(2);
        sys_rst_n = 1'b1;
        tick(1);
        clear_obs();
        send_str("xy");
        send_byte(8'h0A);
        tick(10);
        n_total++; if (first_diff("xy") !== -1) $display("FAIL post_rst_data: diff at %0d (size %0d) want -1", first_diff("xy"), out_q.size()); else n_pass++;
        n_total++; if (line_count !== 16'd1) $display("FAIL post_rst_count: got %0d want 1", line_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_empty_lines();
        test_basic_line();
        test_stall_hold();
        test_overflow();
        test_timeout();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_line_rx.md
Name: uart_line_rx

Overview:
Receive-side counterpart of the demo string sender. It consumes the byte stream from uart_rx (rx_data / rx_data_valid / rx_data_ready) and assembles bytes into lines terminated by LF (0x0A), dropping CR (0x0D). It then replays each completed line as a valid/ready byte stream with a last flag. It sits between uart_rx and any line-oriented consumer, such as a command decoder or an echo path back into uart_tx.

Parameters:
MAX_LEN, 32, line buffer depth in bytes (≥2); LEN_W = $clog2(MAX_LEN+1) derived internally
TIMEOUT_CYC, 2700000, idle cycles (0.1 s at 27 MHz) after which a partial line is discarded; 0 disables the timeout

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  byte from uart_rx
rx_data_valid  in  1  byte present; upstream holds byte and valid until accepted
rx_data_ready  out  1  block can accept a byte this cycle
line_data  out  8  current output byte
line_valid  out  1  line_data valid
line_ready  in  1  consumer accepts line_data
line_last  out  1  current byte is the final byte of the line
line_len  out  LEN_W  byte count of the line being drained
line_done  out  1  1-cycle pulse when a line is committed
err_overflow  out  1  1-cycle pulse on line overflow
err_timeout  out  1  1-cycle pulse on partial-line timeout
line_count  out  16  lines fully drained, wraps 0xFFFF→0

Behaviour:
- Reset (asynchronous): state=COLLECT, wr_ptr=0, rd_ptr=0, idle_cnt=0, line_len=0, line_count=0.
  - Outputs at reset: line_valid=0, line_last=0, line_done=0, err_*=0, rx_data_ready=1.
  - Buffer contents are don't-care.
- A byte is accepted when rx_data_valid && rx_data_ready. The line output is consumed when line_valid && line_ready.
- rx_data_ready = (state != DRAIN). It is a combinational decode of the registered state.
- COLLECT state:
  - CR accepted → dropped; no store, no state change.
  - LF accepted with wr_ptr==0 → ignored. Empty lines produce no output.
  - LF accepted with wr_ptr>0 → line_len<=wr_ptr, rd_ptr<=0, line_done pulse next cycle, → DRAIN. line_valid rises the cycle after LF acceptance (latency 1).
  - Other byte with wr_ptr<MAX_LEN → buf[wr_ptr]<=rx_data, wr_ptr+1.
  - Other byte with wr_ptr==MAX_LEN → err_overflow pulse, wr_ptr<=0, → DISCARD. A line of exactly MAX_LEN bytes followed by LF is legal.
  - Timeout: idle_cnt clears on every accepted byte and on wr_ptr==0; otherwise it increments. When idle_cnt reaches TIMEOUT_CYC-1 with wr_ptr>0 → wr_ptr<=0, idle_cnt<=0, err_timeout pulse. Inactive when TIMEOUT_CYC==0.
- DISCARD state: rx_data_ready=1. All bytes are dropped until LF is accepted → COLLECT with wr_ptr=0. No timeout applies, and no further err_overflow pulses.
- DRAIN state:
  - Outputs: line_valid=1, line_data=buf[rd_ptr], line_last=(rd_ptr==line_len-1).
  - While line_valid && !line_ready: line_data, line_last and line_len hold stable.
  - On a beat that is not last: rd_ptr+1.
  - On the last beat: line_valid<=0, wr_ptr<=0, line_count+1, → COLLECT. rx_data_ready is 1 from the next cycle.
  - Incoming bytes are not accepted (ready=0); upstream holds them.
- line_len holds its value until the next commit.
- Simultaneous events:
  - Timeout expiry coinciding with an accepted byte → the byte wins; the counter clears and no timeout fires.
  - A byte accepted in the same cycle as the overflow condition is the dropped one.
- Reset mid-DRAIN or mid-COLLECT: line_valid drops immediately (asynchronously) and the partial or pending line is lost.
- Illegal state encoding → COLLECT with wr_ptr=0.

Test Plan:
1. Send "Hello Tang Nano 20K" 0x0D 0x0A, line_ready=1 → line_done one pulse; line_len=19; 19 beats 'H'…'K'; line_last only on 'K'; no 0x0D emitted; line_count=1.
2. Same line with line_ready toggling 1,0,0,1 and a new byte offered during DRAIN → line_data/line_last stable while stalled; rx_data_ready=0 throughout DRAIN; byte order exact; the held byte is accepted the cycle after the last beat.
3. MAX_LEN=32: 32×'A'+LF → line_len=32, 32 beats. Then 40×'B'+LF → err_overflow single pulse on the 33rd 'B', no output; then "ok\n" → 2 beats "ok".
4. Stream 0x0D 0x0A 0x0A 0x0D → no line_valid, no line_done, line_count stays 0.
5. TIMEOUT_CYC=100: "ab" then idle → err_timeout pulse 100 cycles after 'b'. Then "cd\n" → line_len=2, output "cd" only.
6. Assert sys_rst_n=0 after 3 beats of a 10-byte DRAIN → line_valid=0 same cycle, line_count=0, rx_data_ready=1. Release reset, then "xy\n" → 2 beats "xy", line_count=1.
